// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction buffer: in-order {pc, instr} FIFO with
// first-word fall-through, full back-pressure and branch-redirect flush.
module fetch_decode_queue #(
    parameter int WIDTH       = 8,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_pc,
    input  logic [INSTR_WIDTH-1:0]     in_instr,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_pc,
    output logic [INSTR_WIDTH-1:0]     out_instr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0]       pc_mem    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt_q;

    logic push;
    logic pop;
    logic full;
    logic empty;

    // Ready depends on occupancy only, so a full queue never
    // accepts on the strength of a same-cycle pop.
    assign full      = (cnt_q == CW'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Payload storage carries no reset; validity lives in the count.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    always_comb begin
        out_pc    = '0;
        out_instr = '0;
        if (out_valid) begin
            out_pc    = pc_mem[rd_ptr];
            out_instr = instr_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: vector table, directed corner sequences
// and a randomized run, all checked against a queue scoreboard.
module tb_fetch_decode_queue;

    localparam int WIDTH       = 8;
    localparam int INSTR_WIDTH = 32;
    localparam int DEPTH       = 4;

    logic                   clock;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_pc;
    logic [INSTR_WIDTH-1:0] in_instr;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_pc;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [2:0]             count;

    fetch_decode_queue #(
        .WIDTH(WIDTH),
        .INSTR_WIDTH(INSTR_WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pc(in_pc),
        .in_instr(in_instr),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_instr(out_instr),
        .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [WIDTH-1:0]       pc;
        logic [INSTR_WIDTH-1:0] instr;
    } ent_t;

    typedef struct {
        logic             iv;
        logic [WIDTH-1:0] pc;
        logic             fl;
        logic             ordy;
        int               cnt;
        logic             ov;
        logic [WIDTH-1:0] opc;
        logic             ir;
    } vec_t;

    ent_t q[$];
    int   checks;
    int   failures;

    function automatic logic [INSTR_WIDTH-1:0] mk(input logic [WIDTH-1:0] pc);
        return {16'hBEEF, 8'h13, pc} ^ {24'h0, ~pc};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [WIDTH-1:0] pc,
                         input logic fl, input logic ordy);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = mk(pc);
        flush     = fl;
        out_ready = ordy;
    endtask

    // One clock with scoreboard bookkeeping; called at posedge+1.
    task automatic cycle();
        ent_t e;
        int   sz;
        #1;
        sz = q.size();
        chk("in_ready_pre", in_ready, sz != DEPTH);
        chk("out_valid_pre", out_valid, sz != 0);
        if (out_ready && sz != 0) begin
            e = q.pop_front();
            chk("pop_pc", out_pc, e.pc);
            chk("pop_instr", out_instr, e.instr);
        end
        if (flush) begin
            q.delete();
        end else if (in_valid && sz != DEPTH) begin
            e.pc    = in_pc;
            e.instr = in_instr;
            q.push_back(e);
        end
        @(posedge clock);
        #1;
        sz = q.size();
        chk("count", count, sz);
        chk("out_valid", out_valid, sz != 0);
        chk("in_ready", in_ready, sz != DEPTH);
        chk("out_pc", out_pc, sz != 0 ? q[0].pc : 0);
        chk("out_instr", out_instr, sz != 0 ? q[0].instr : 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    vec_t tbl[6];
    logic [WIDTH-1:0] prev;

    initial begin
        checks   = 0;
        failures = 0;

        tbl[0] = '{1'b1, 8'h00, 1'b0, 1'b0, 1, 1'b1, 8'h00, 1'b1};
        tbl[1] = '{1'b1, 8'h04, 1'b0, 1'b0, 2, 1'b1, 8'h00, 1'b1};
        tbl[2] = '{1'b1, 8'h08, 1'b0, 1'b0, 3, 1'b1, 8'h00, 1'b1};
        tbl[3] = '{1'b1, 8'h0C, 1'b0, 1'b0, 4, 1'b1, 8'h00, 1'b0};
        tbl[4] = '{1'b1, 8'h10, 1'b0, 1'b1, 3, 1'b1, 8'h04, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 3, 1'b1, 8'h04, 1'b1};

        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Fill, full refusal, pop from full.
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].iv, tbl[i].pc, tbl[i].fl, tbl[i].ordy);
            cycle();
            chk($sformatf("vec%0d_count", i), count, tbl[i].cnt);
            chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].ov);
            chk($sformatf("vec%0d_out_pc", i), out_pc, tbl[i].opc);
            chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].ir);
        end

        // Streaming push&pop across pointer wrap.
        do_reset();
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 8'h04, 1'b0, 1'b0);
        cycle();
        prev = out_pc;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, WIDTH'(8 + 4 * i), 1'b0, 1'b1);
            cycle();
            chk("stream_count", count, 2);
            chk("stream_step", out_pc, WIDTH'(prev + 8'd4));
            prev = out_pc;
        end

        // Flush discards queued entries and the flush-cycle push.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, WIDTH'(4 * i), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 8'h20, 1'b1, 1'b0);
        cycle();
        chk("flush_count", count, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        drive(1'b1, 8'h40, 1'b0, 1'b0);
        cycle();
        chk("flush_target_pc", out_pc, 8'h40);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        cycle();
        chk("flush_drained", count, 0);

        // Flush coinciding with a pop.
        drive(1'b1, 8'h50, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 8'h54, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 8'h58, 1'b1, 1'b1);
        cycle();
        chk("flush_pop_count", count, 0);

        // Asynchronous reset between edges.
        drive(1'b1, 8'h60, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 8'h64, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_out_pc", out_pc, 0);
        chk("arst_in_ready", in_ready, 1);
        q.delete();
        #2;
        reset = 1'b0;
        drive(1'b1, 8'h70, 1'b0, 1'b0);
        cycle();
        chk("arst_after_pc", out_pc, 8'h70);
        drive(1'b1, 8'h74, 1'b0, 1'b1);
        cycle();
        chk("arst_after_pc2", out_pc, 8'h74);

        // Empty pop is ignored.
        do_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        cycle();
        cycle();
        chk("empty_pop_count", count, 0);
        drive(1'b1, 8'h10, 1'b0, 1'b0);
        cycle();
        chk("empty_push_valid", out_valid, 1);
        chk("empty_push_pc", out_pc, 8'h10);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), WIDTH'($urandom),
                  $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
